// File: rtl/fetcher.sv
// Per-warp PC holder and round-robin fetch scheduler for one compute unit.
// Ports: clk_i/rst_i (sync, active-high); start_* warp launch; ib_space_i
// per-warp buffer room; ic_ready_i/fe_* fetch request to the I-cache;
// dec_* decoder feedback; bru_* branch resolution; all_stopped_o.
// Optional BGPU_FETCHER_PERF_EN adds perf_fetches_o/perf_stall_cycles_o.
module fetcher #(
  parameter int FetchWidth     = 1,
  parameter int PcWidth        = 32,
  parameter int NumWarps       = 8,
  parameter int WarpWidth      = 32,
  parameter int WidWidth       = (NumWarps > 1) ? $clog2(NumWarps) : 1,
  parameter int SubwarpIdWidth = (WarpWidth > 1) ? $clog2(WarpWidth) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_valid_i,
  output logic                      start_ready_o,
  input  logic [PcWidth-1:0]        start_pc_i,
  input  logic [NumWarps-1:0]       ib_space_i,
  input  logic                      ic_ready_i,
  output logic                      fe_valid_o,
  output logic [PcWidth-1:0]        fe_pc_o,
  output logic [WarpWidth-1:0]      fe_act_mask_o,
  output logic [WidWidth-1:0]       fe_warp_id_o,
  output logic [SubwarpIdWidth-1:0] fe_subwarp_id_o,
  output logic [FetchWidth-1:0]     fe_fetch_mask_o,
  input  logic                      dec_decoded_i,
  input  logic                      dec_stop_warp_i,
  input  logic                      dec_decoded_branch_i,
  input  logic                      dec_decoded_sync_i,
  input  logic [WidWidth-1:0]       dec_decoded_warp_id_i,
  input  logic [PcWidth-1:0]        dec_decoded_next_pc_i,
  input  logic                      bru_valid_i,
  input  logic [WidWidth-1:0]       bru_warp_id_i,
  input  logic [PcWidth-1:0]        bru_next_pc_i,
  output logic                      all_stopped_o
`ifdef BGPU_FETCHER_PERF_EN
  ,
  output logic [31:0]               perf_fetches_o,
  output logic [31:0]               perf_stall_cycles_o
`endif
);

  typedef enum logic [2:0] {
    INACTIVE, READY, FETCHING, WAIT_BRANCH, WAIT_SYNC
  } wstate_e;

  wstate_e                   state_q [NumWarps];
  wstate_e                   state_d [NumWarps];
  logic [PcWidth-1:0]        pc_q    [NumWarps];
  logic [PcWidth-1:0]        pc_d    [NumWarps];
  logic [WarpWidth-1:0]      amask_q [NumWarps];
  logic [WarpWidth-1:0]      amask_d [NumWarps];
  logic [SubwarpIdWidth-1:0] sub_q   [NumWarps];
  logic [SubwarpIdWidth-1:0] sub_d   [NumWarps];

  logic [WidWidth-1:0] rr_q, rr_d;
  logic [WidWidth-1:0] lock_wid_q;
  logic                lock_q;

  logic [NumWarps-1:0] eligible;
  logic                any_inactive, all_inactive;
  logic                sync_any, sync_all, sync_rel;
  logic                rr_hit;
  logic [WidWidth-1:0] rr_wid, grant_wid, launch_wid;
  logic                launch, handshake;
  logic [PcWidth-1:0]  blk_off;

  always_comb begin
    eligible     = '0;
    any_inactive = 1'b0;
    all_inactive = 1'b1;
    sync_any     = 1'b0;
    sync_all     = 1'b1;
    launch_wid   = '0;
    for (int w = NumWarps - 1; w >= 0; w--) begin
      eligible[w] = (state_q[w] == READY) && ib_space_i[w];
      if (state_q[w] == INACTIVE) begin
        any_inactive = 1'b1;
        launch_wid   = WidWidth'(w);
      end else begin
        all_inactive = 1'b0;
      end
      if (state_q[w] == WAIT_SYNC) sync_any = 1'b1;
      else if (state_q[w] != INACTIVE) sync_all = 1'b0;
    end
    sync_rel = sync_any && sync_all;
  end

  // First eligible warp at or after the pointer.
  always_comb begin
    rr_hit = 1'b0;
    rr_wid = rr_q;
    for (int k = 0; k < NumWarps; k++) begin
      if (!rr_hit && eligible[(int'(rr_q) + k) % NumWarps]) begin
        rr_hit = 1'b1;
        rr_wid = WidWidth'((int'(rr_q) + k) % NumWarps);
      end
    end
  end

  // A stalled request stays pinned to its warp until accepted.
  assign grant_wid     = lock_q ? lock_wid_q : rr_wid;
  assign fe_valid_o    = lock_q || rr_hit;
  assign handshake     = fe_valid_o && ic_ready_i;
  assign start_ready_o = any_inactive;
  assign all_stopped_o = all_inactive;
  assign launch        = start_valid_i && any_inactive;

  assign fe_warp_id_o    = grant_wid;
  assign fe_pc_o         = pc_q[grant_wid];
  assign fe_act_mask_o   = amask_q[grant_wid];
  assign fe_subwarp_id_o = sub_q[grant_wid];
  assign blk_off = pc_q[grant_wid] & PcWidth'(FetchWidth - 1);

  always_comb begin
    for (int i = 0; i < FetchWidth; i++) begin
      fe_fetch_mask_o[i] = (PcWidth'(i) >= blk_off);
    end
  end

  assign rr_d = handshake
    ? WidWidth'((int'(grant_wid) + 1) % NumWarps) : rr_q;

  always_comb begin
    for (int w = 0; w < NumWarps; w++) begin
      state_d[w] = state_q[w];
      pc_d[w]    = pc_q[w];
      amask_d[w] = amask_q[w];
      sub_d[w]   = sub_q[w];
      if (launch && launch_wid == WidWidth'(w)) begin
        state_d[w] = READY;
        pc_d[w]    = start_pc_i;
        amask_d[w] = '1;
        sub_d[w]   = '0;
      end
      if (handshake && grant_wid == WidWidth'(w)) begin
        state_d[w] = FETCHING;
      end
      if (sync_rel && state_q[w] == WAIT_SYNC) begin
        state_d[w] = READY;
      end
      if (bru_valid_i && bru_warp_id_i == WidWidth'(w)
          && state_q[w] == WAIT_BRANCH) begin
        state_d[w] = READY;
        pc_d[w]    = bru_next_pc_i;
      end
      if (dec_decoded_i && dec_decoded_warp_id_i == WidWidth'(w)
          && state_q[w] == FETCHING) begin
        unique case (1'b1)
          dec_stop_warp_i: state_d[w] = INACTIVE;
          dec_decoded_branch_i: state_d[w] = WAIT_BRANCH;
          dec_decoded_sync_i: begin
            state_d[w] = WAIT_SYNC;
            pc_d[w]    = dec_decoded_next_pc_i;
          end
          default: begin
            state_d[w] = READY;
            pc_d[w]    = dec_decoded_next_pc_i;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < NumWarps; w++) begin
        state_q[w] <= INACTIVE;
        pc_q[w]    <= '0;
        amask_q[w] <= '0;
        sub_q[w]   <= '0;
      end
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_wid_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      amask_q    <= amask_d;
      sub_q      <= sub_d;
      rr_q       <= rr_d;
      lock_q     <= fe_valid_o && !ic_ready_i;
      lock_wid_q <= grant_wid;
    end
  end

`ifdef BGPU_FETCHER_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fetches_o      <= '0;
      perf_stall_cycles_o <= '0;
    end else begin
      if (handshake && perf_fetches_o != '1)
        perf_fetches_o <= perf_fetches_o + 32'd1;
      if (fe_valid_o && !ic_ready_i && perf_stall_cycles_o != '1)
        perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
    end
  end
`else
`endif

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i && dec_decoded_i)
      assert (state_q[dec_decoded_warp_id_i] == FETCHING)
        else $error("fetcher: decode for a warp not fetching");
    if (!rst_i && bru_valid_i)
      assert (state_q[bru_warp_id_i] == WAIT_BRANCH)
        else $error("fetcher: bru for a warp not waiting on branch");
  end
`endif

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher (FetchWidth=4, 8 warps).
// Expected values are hand-computed constants.
module tb_fetcher;
  localparam int FW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] start_pc = '0;
  logic [7:0]  ib_space = 8'hFF;
  logic        ic_ready = 1'b0;
  logic        fe_valid;
  logic [31:0] fe_pc;
  logic [31:0] fe_act_mask;
  logic [2:0]  fe_wid;
  logic [4:0]  fe_sub;
  logic [3:0]  fe_fmask;
  logic        dec = 1'b0;
  logic        dec_stop = 1'b0;
  logic        dec_br = 1'b0;
  logic        dec_sync = 1'b0;
  logic [2:0]  dec_wid = '0;
  logic [31:0] dec_npc = '0;
  logic        bru_valid = 1'b0;
  logic [2:0]  bru_wid = '0;
  logic [31:0] bru_npc = '0;
  logic        all_stopped;
`ifdef BGPU_FETCHER_PERF_EN
  logic [31:0] perf_f, perf_s;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetcher #(.FetchWidth(FW)) dut (
    .clk_i(clk), .rst_i(rst),
    .start_valid_i(start_valid), .start_ready_o(start_ready),
    .start_pc_i(start_pc), .ib_space_i(ib_space),
    .ic_ready_i(ic_ready), .fe_valid_o(fe_valid),
    .fe_pc_o(fe_pc), .fe_act_mask_o(fe_act_mask),
    .fe_warp_id_o(fe_wid), .fe_subwarp_id_o(fe_sub),
    .fe_fetch_mask_o(fe_fmask),
    .dec_decoded_i(dec), .dec_stop_warp_i(dec_stop),
    .dec_decoded_branch_i(dec_br), .dec_decoded_sync_i(dec_sync),
    .dec_decoded_warp_id_i(dec_wid),
    .dec_decoded_next_pc_i(dec_npc),
    .bru_valid_i(bru_valid), .bru_warp_id_i(bru_wid),
    .bru_next_pc_i(bru_npc), .all_stopped_o(all_stopped)
`ifdef BGPU_FETCHER_PERF_EN
    , .perf_fetches_o(perf_f), .perf_stall_cycles_o(perf_s)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] pc);
    start_valid = 1'b1;
    start_pc    = pc;
    step();
    start_valid = 1'b0;
  endtask

  task automatic fetch();
    ic_ready = 1'b1;
    step();
    ic_ready = 1'b0;
  endtask

  task automatic decode(input logic [2:0] w, input logic [31:0] npc,
                        input logic st, input logic br, input logic sy);
    dec      = 1'b1;
    dec_wid  = w;
    dec_npc  = npc;
    dec_stop = st;
    dec_br   = br;
    dec_sync = sy;
    step();
    dec      = 1'b0;
    dec_stop = 1'b0;
    dec_br   = 1'b0;
    dec_sync = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [2:0]  exp_wid [6] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
  logic [31:0] exp_pc  [6] = '{32'h40, 32'h80, 32'hC0,
                               32'h44, 32'h84, 32'hC4};

  initial begin
    do_reset();
    check("rst_valid", 64'(fe_valid), 64'd0);
    check("rst_start_ready", 64'(start_ready), 64'd1);
    check("rst_all_stopped", 64'(all_stopped), 64'd1);

    launch(32'h40);
    check("l40_valid", 64'(fe_valid), 64'd1);
    check("l40_pc", 64'(fe_pc), 64'h40);
    check("l40_wid", 64'(fe_wid), 64'd0);
    check("l40_fmask", 64'(fe_fmask), 64'hF);
    check("l40_amask", 64'(fe_act_mask), 64'hFFFF_FFFF);
    check("l40_sub", 64'(fe_sub), 64'd0);
    check("l40_all_stopped", 64'(all_stopped), 64'd0);
    fetch();
    check("fetching_valid", 64'(fe_valid), 64'd0);
    decode(3'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("stop0_all_stopped", 64'(all_stopped), 64'd1);

    launch(32'h42);
    check("l42_wid", 64'(fe_wid), 64'd0);
    check("l42_pc", 64'(fe_pc), 64'h42);
    check("l42_fmask", 64'(fe_fmask), 64'hC);
    fetch();
    decode(3'd0, 32'h44, 1'b0, 1'b0, 1'b0);
    check("npc44_pc", 64'(fe_pc), 64'h44);
    check("npc44_fmask", 64'(fe_fmask), 64'hF);

    do_reset();
    launch(32'h40);
    launch(32'h80);
    launch(32'hC0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr%0d_valid", k), 64'(fe_valid), 64'd1);
      check($sformatf("rr%0d_wid", k), 64'(fe_wid), 64'(exp_wid[k]));
      check($sformatf("rr%0d_pc", k), 64'(fe_pc), 64'(exp_pc[k]));
      if (k > 0) begin
        dec     = 1'b1;
        dec_wid = exp_wid[k-1];
        dec_npc = exp_pc[k-1] + 32'd4;
      end
      ic_ready = 1'b1;
      step();
      dec = 1'b0;
    end
    ic_ready = 1'b0;
    decode(3'd2, 32'hC8, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      ib_space = 8'hFE;
      check($sformatf("stall%0d_valid", k), 64'(fe_valid), 64'd1);
      check($sformatf("stall%0d_wid", k), 64'(fe_wid), 64'd0);
      check($sformatf("stall%0d_pc", k), 64'(fe_pc), 64'h48);
      step();
    end
    ib_space = 8'hFF;

    fetch();
    check("post_stall_wid", 64'(fe_wid), 64'd1);
    check("post_stall_pc", 64'(fe_pc), 64'h88);
    fetch();
    check("w2_pc", 64'(fe_pc), 64'hC8);
    decode(3'd1, 32'h0, 1'b0, 1'b1, 1'b0);
    fetch();
    check("br_wait_valid", 64'(fe_valid), 64'd0);
    bru_valid = 1'b1;
    bru_wid   = 3'd1;
    bru_npc   = 32'h100;
    step();
    bru_valid = 1'b0;
    check("bru_valid", 64'(fe_valid), 64'd1);
    check("bru_wid", 64'(fe_wid), 64'd1);
    check("bru_pc", 64'(fe_pc), 64'h100);

    fetch();
    decode(3'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    decode(3'd2, 32'h0, 1'b1, 1'b0, 1'b0);
    launch(32'h500);
    check("l500_wid", 64'(fe_wid), 64'd0);
    fetch();
    decode(3'd0, 32'h504, 1'b0, 1'b0, 1'b1);
    check("sync0_wait_valid", 64'(fe_valid), 64'd0);
    check("sync0_all_stopped", 64'(all_stopped), 64'd0);
    decode(3'd1, 32'h104, 1'b0, 1'b0, 1'b1);
    check("sync_both_valid", 64'(fe_valid), 64'd0);
    ib_space = 8'h01;
    step();
    check("rel_w0_valid", 64'(fe_valid), 64'd1);
    check("rel_w0_wid", 64'(fe_wid), 64'd0);
    check("rel_w0_pc", 64'(fe_pc), 64'h504);
    ib_space = 8'h02;
    #1;
    check("rel_w1_wid", 64'(fe_wid), 64'd1);
    check("rel_w1_pc", 64'(fe_pc), 64'h104);
    ib_space = 8'hFF;
    #1;
    fetch();
    fetch();
    decode(3'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    decode(3'd1, 32'h0, 1'b1, 1'b0, 1'b0);
    check("end_all_stopped", 64'(all_stopped), 64'd1);
    check("end_start_ready", 64'(start_ready), 64'd1);
    check("end_valid", 64'(fe_valid), 64'd0);

    launch(32'h600);
    step();
    check("pend_valid", 64'(fe_valid), 64'd1);
    rst = 1'b1;
    step();
    check("midrst_valid", 64'(fe_valid), 64'd0);
    rst = 1'b0;
    step();
    check("postrst_valid", 64'(fe_valid), 64'd0);
    check("postrst_all_stopped", 64'(all_stopped), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
